// File: rtl/s4ga_cfg_streamer.sv
// Configuration streamer for the s4ga LUT fabric: stores one bitstream image,
// then drives the fabric reset window and replays the image one segment per clock.
module s4ga_cfg_streamer #(
  parameter int N          = 13,
  parameter int K          = 4,
  parameter int SI_W       = 4,
  parameter int RST_CYCLES = N + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            wr_valid_i,
  input  logic [SI_W-1:0] wr_data_i,
  output logic            wr_ready_o,
  output logic [SI_W-1:0] fab_si_o,
  output logic            fab_rst_o,
  output logic            running_o,
  output logic            loaded_o,
  output logic            lut_last_o,
  output logic            pass_last_o,
  output logic [7:0]      pass_cnt_o
);

  localparam int N_W        = $clog2(N);
  localparam int IDX_SEGS   = (N_W + SI_W - 1) / SI_W;
  localparam int MASK_SEGS  = ((1 << K) + SI_W - 1) / SI_W;
  localparam int FRAME_SEGS = K * IDX_SEGS + MASK_SEGS;
  localparam int DEPTH      = N * FRAME_SEGS;
  localparam int A_W        = $clog2(DEPTH);
  localparam int RC_W       = $clog2(RST_CYCLES + 1);
  localparam int FS_W       = (FRAME_SEGS > 1) ? $clog2(FRAME_SEGS) : 1;

  localparam logic [A_W-1:0]  LAST_ADDR = A_W'(DEPTH - 1);
  localparam logic [FS_W-1:0] LAST_FS   = FS_W'(FRAME_SEGS - 1);
  localparam logic [RC_W-1:0] LAST_RC   = RC_W'(RST_CYCLES - 1);

  if (RST_CYCLES <= N) begin : g_bad_rst_cycles
    $error("s4ga_cfg_streamer: RST_CYCLES must be greater than N");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RESET, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [A_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [A_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FS_W-1:0] fs_q, fs_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic            loaded_q, loaded_d;
  logic [SI_W-1:0] fab_si_q, fab_si_d;
  logic            fab_rst_q, fab_rst_d;
  logic            lut_last_q, lut_last_d;
  logic            pass_last_q, pass_last_d;
  logic [7:0]      pass_cnt_q, pass_cnt_d;

  logic [A_W-1:0]  pres_idx, nxt_idx;
  logic [FS_W-1:0] pres_fs, nxt_fs;
  logic            wr_en;

  logic [SI_W-1:0] mem [DEPTH];

  assign wr_ready_o = (state_q == S_LOAD);
  assign wr_en      = wr_ready_o && wr_valid_i;

  // NOTE: the image storage has no reset, so the contents survive rst and the
  // array maps onto plain registers or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data_i;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fs_d     = fs_q;
    rc_d     = rc_q;
    loaded_d = loaded_q;

    // Entry into RUN always presents segment 0; afterwards the read pointer leads.
    pres_idx = (state_q == S_RUN) ? rd_ptr_q : '0;
    pres_fs  = (state_q == S_RUN) ? fs_q : '0;
    nxt_idx  = (pres_idx == LAST_ADDR) ? '0 : pres_idx + A_W'(1);
    nxt_fs   = (pres_fs == LAST_FS) ? '0 : pres_fs + FS_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (load_i) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
          loaded_d = 1'b0;
        end else if (start_i && loaded_q) begin
          state_d = S_RESET;
          rc_d    = '0;
        end
      end
      S_LOAD: begin
        if (load_i) begin
          wr_ptr_d = '0;
        end else if (stop_i) begin
          state_d  = S_IDLE;
          loaded_d = 1'b0;
        end else if (wr_valid_i) begin
          if (wr_ptr_q == LAST_ADDR) begin
            state_d  = S_RESET;
            wr_ptr_d = '0;
            loaded_d = 1'b1;
            rc_d     = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + A_W'(1);
          end
        end
      end
      S_RESET, S_RUN: begin
        if (load_i) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
          loaded_d = 1'b0;
        end else if (stop_i) begin
          state_d = S_IDLE;
        end else if (state_q == S_RUN || rc_q == LAST_RC) begin
          state_d  = S_RUN;
          rd_ptr_d = nxt_idx;
          fs_d     = nxt_fs;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    fab_rst_d   = (state_d != S_RUN);
    fab_si_d    = fab_rst_d ? '0 : mem[pres_idx];
    lut_last_d  = !fab_rst_d && (pres_fs == LAST_FS);
    pass_last_d = !fab_rst_d && (pres_idx == LAST_ADDR);
    pass_cnt_d  = pass_cnt_q + 8'(pass_last_q);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fs_q        <= '0;
      rc_q        <= '0;
      loaded_q    <= 1'b0;
      fab_si_q    <= '0;
      fab_rst_q   <= 1'b1;
      lut_last_q  <= 1'b0;
      pass_last_q <= 1'b0;
      pass_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fs_q        <= fs_d;
      rc_q        <= rc_d;
      loaded_q    <= loaded_d;
      fab_si_q    <= fab_si_d;
      fab_rst_q   <= fab_rst_d;
      lut_last_q  <= lut_last_d;
      pass_last_q <= pass_last_d;
      pass_cnt_q  <= pass_cnt_d;
    end
  end

  assign fab_si_o    = fab_si_q;
  assign fab_rst_o   = fab_rst_q;
  assign running_o   = (state_q == S_RUN);
  assign loaded_o    = loaded_q;
  assign lut_last_o  = lut_last_q;
  assign pass_last_o = pass_last_q;
  assign pass_cnt_o  = pass_cnt_q;

endmodule

// File: tb/tb_s4ga_cfg_streamer.sv
// Self-checking bench for s4ga_cfg_streamer: a reference image model feeds a
// queue of expected stream beats that are compared as the DUT presents them.
module tb_s4ga_cfg_streamer;

  localparam int DEPTH = 104;
  localparam int RST   = 14;
  localparam int FRAME = 8;

  logic       clk = 1'b0;
  logic       rst, load, start, stop, wr_valid;
  logic [3:0] wr_data;
  logic       wr_ready, fab_rst, running, loaded, lut_last, pass_last;
  logic [3:0] fab_si;
  logic [7:0] pass_cnt;

  s4ga_cfg_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .start_i    (start),
    .stop_i     (stop),
    .wr_valid_i (wr_valid),
    .wr_data_i  (wr_data),
    .wr_ready_o (wr_ready),
    .fab_si_o   (fab_si),
    .fab_rst_o  (fab_rst),
    .running_o  (running),
    .loaded_o   (loaded),
    .lut_last_o (lut_last),
    .pass_last_o(pass_last),
    .pass_cnt_o (pass_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       f_rst;
    logic [3:0] si;
    logic       lut;
    logic       pl;
  } beat_t;

  int         checks = 0;
  int         failures = 0;
  int         exp_pass_cnt = 0;
  logic [3:0] model_mem [DEPTH];
  beat_t      exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input int start_idx, input int n);
    for (int j = 0; j < n; j++) begin
      int    idx;
      beat_t e;
      idx     = (start_idx + j) % DEPTH;
      e.f_rst = 1'b0;
      e.si    = model_mem[idx];
      e.lut   = (idx % FRAME) == FRAME - 1;
      e.pl    = (idx == DEPTH - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain_stream(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      beat_t e, a;
      e = exp_q.pop_front();
      a = {fab_rst, fab_si, lut_last, pass_last};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s beat %0d: got rst=%0b si=%0d lut=%0b pl=%0b, expected rst=%0b si=%0d lut=%0b pl=%0b",
                 name, n, a.f_rst, a.si, a.lut, a.pl, e.f_rst, e.si, e.lut, e.pl);
      end
      if (e.pl) exp_pass_cnt++;
      n++;
      step();
    end
  endtask

  task automatic count_reset_window(input string name);
    int n;
    n = 0;
    while (fab_rst === 1'b1 && n < 200) begin
      n++;
      step();
    end
    checks++;
    if (n != RST) begin
      failures++;
      $display("FAIL %s reset_window: got %0d fab_rst cycles, expected %0d", name, n, RST);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; wr_valid = 1'b0; wr_data = '0;
    step();
    step();
    rst = 1'b0;
    checks++; if (fab_rst !== 1'b1) begin failures++; $display("FAIL reset fab_rst: got %0b expected 1", fab_rst); end
    checks++; if (fab_si !== 4'd0) begin failures++; $display("FAIL reset fab_si: got %0d expected 0", fab_si); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset running: got %0b expected 0", running); end
    checks++; if (loaded !== 1'b0) begin failures++; $display("FAIL reset loaded: got %0b expected 0", loaded); end
    checks++; if (pass_cnt !== 8'd0) begin failures++; $display("FAIL reset pass_cnt: got %0d expected 0", pass_cnt); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset wr_ready: got %0b expected 0", wr_ready); end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++; if (running !== 1'b0 || fab_rst !== 1'b1 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL unloaded_start: got running=%0b fab_rst=%0b wr_ready=%0b expected 0/1/0", running, fab_rst, wr_ready);
    end
  endtask

  task automatic test_load_gaps();
    int i, c;
    load = 1'b1;
    step();
    load = 1'b0;
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL load_ready: got %0b expected 1", wr_ready); end
    i = 0;
    c = 0;
    while (i < DEPTH && c < 1000) begin
      logic take;
      wr_valid = (c % 3) != 2;
      wr_data  = 4'(i % 16);
      take     = wr_valid && wr_ready;
      if (take) begin
        model_mem[i] = wr_data;
        i++;
      end
      step();
      c++;
    end
    wr_valid = 1'b0;
    checks++; if (i != DEPTH) begin failures++; $display("FAIL load_accept: got %0d writes accepted expected %0d", i, DEPTH); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL load_done_ready: got %0b expected 0", wr_ready); end
    checks++; if (loaded !== 1'b1) begin failures++; $display("FAIL load_done_loaded: got %0b expected 1", loaded); end
    count_reset_window("first_start");
    push_stream(0, 8);
    drain_stream("first_stream");
  endtask

  task automatic test_wrap();
    push_stream(8, 210);
    drain_stream("wrap");
    checks++; if (pass_cnt !== 8'(exp_pass_cnt) || exp_pass_cnt != 2) begin
      failures++;
      $display("FAIL wrap_pass_cnt: got %0d expected 2", pass_cnt);
    end
  endtask

  task automatic test_stop_restart();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if ({fab_rst, fab_si, lut_last, pass_last, running} !== {1'b1, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL stop_latency: got rst=%0b si=%0d lut=%0b pl=%0b run=%0b expected 1/0/0/0/0",
               fab_rst, fab_si, lut_last, pass_last, running);
    end
    repeat (5) step();
    checks++; if (fab_rst !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("FAIL stop_hold: got fab_rst=%0b running=%0b expected 1/0", fab_rst, running);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    count_reset_window("restart");
    push_stream(0, 12);
    drain_stream("restart_stream");
    checks++; if (pass_cnt !== 8'(exp_pass_cnt)) begin
      failures++;
      $display("FAIL restart_pass_cnt: got %0d expected %0d", pass_cnt, exp_pass_cnt);
    end
  endtask

  task automatic test_simultaneous();
    load = 1'b1; stop = 1'b1; start = 1'b1;
    step();
    load = 1'b0; stop = 1'b0; start = 1'b0;
    checks++; if ({running, loaded, fab_rst, wr_ready} !== 4'b0011) begin
      failures++;
      $display("FAIL simultaneous: got running=%0b loaded=%0b fab_rst=%0b wr_ready=%0b expected 0/0/1/1",
               running, loaded, fab_rst, wr_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 50; i++) begin
      wr_valid = 1'b1;
      wr_data  = 4'((i * 5 + 3) % 16);
      step();
    end
    wr_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_pass_cnt = 0;
    checks++; if ({running, loaded, wr_ready, pass_cnt} !== {3'b000, 8'd0}) begin
      failures++;
      $display("FAIL mid_load_rst: got running=%0b loaded=%0b wr_ready=%0b pass_cnt=%0d expected 0/0/0/0",
               running, loaded, wr_ready, pass_cnt);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    checks++; if (running !== 1'b0 || fab_rst !== 1'b1) begin
      failures++;
      $display("FAIL mid_load_start_ignored: got running=%0b fab_rst=%0b expected 0/1", running, fab_rst);
    end
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid     = 1'b1;
      wr_data      = 4'((i * 7 + 3) % 16);
      model_mem[i] = wr_data;
      step();
    end
    wr_valid = 1'b0;
    checks++; if (loaded !== 1'b1 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL reload_done: got loaded=%0b wr_ready=%0b expected 1/0", loaded, wr_ready);
    end
    count_reset_window("reload");
    push_stream(0, 110);
    drain_stream("reload_stream");
    checks++; if (pass_cnt !== 8'(exp_pass_cnt)) begin
      failures++;
      $display("FAIL reload_pass_cnt: got %0d expected %0d", pass_cnt, exp_pass_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_gaps();
    test_wrap();
    test_stop_restart();
    test_simultaneous();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
